// File: rtl/core_types_pkg.sv
// Shared fetch/decode types: prediction-info width, fetch bundle geometry, chunk helpers.
package core_types_pkg;

    localparam int BTB_PRED_INFO_WIDTH     = 8;
    localparam int FETCH_CHUNKS_PER_BUNDLE = 4;
    localparam int FETCH_CHUNK_IDX_W       = $clog2(FETCH_CHUNKS_PER_BUNDLE);

    typedef logic [FETCH_CHUNK_IDX_W-1:0] chunk_idx_t;
    typedef logic [15:0]                  chunk_t;

    // RISC-V length encoding: low bits 2'b11 mark a 32-bit instruction.
    function automatic logic is_uncompressed(input chunk_t c);
        return c[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/instr_chunk_aligner_chunk_select.sv
// Picks the lower/upper chunk and their pred info for the current instruction; purely combinational.
module instr_chunk_aligner_chunk_select
    import core_types_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 8
) (
    input  logic [N-1:0][15:0]         chunks,
    input  logic [N-1:0][PW-1:0]       preds,
    input  logic [$clog2(N)-1:0]       ptr,
    input  logic                       use_straddle,
    input  chunk_t                     straddle_chunk,
    input  logic [PW-1:0]              straddle_pred,
    output chunk_t                     lo_chunk,
    output chunk_t                     hi_chunk,
    output logic [PW-1:0]              lo_pred,
    output logic [PW-1:0]              hi_pred
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] hi_idx;

    // Wraps at the last chunk; the upper half is unused there.
    assign hi_idx = ptr + IDX_W'(1);

    always_comb begin
        if (use_straddle) begin
            lo_chunk = straddle_chunk;
            lo_pred  = straddle_pred;
            hi_chunk = chunks[0];
            hi_pred  = preds[0];
        end else begin
            lo_chunk = chunks[ptr];
            lo_pred  = preds[ptr];
            hi_chunk = chunks[hi_idx];
            hi_pred  = preds[hi_idx];
        end
    end

endmodule

// File: rtl/instr_chunk_aligner.sv
// Re-aligns 16-bit chunk fetch bundles into one instruction per cycle; first output one cycle after accept.
// Holds outputs while out_ready is low; takes a new bundle in the cycle the last chunk leaves.
module instr_chunk_aligner
    import core_types_pkg::*;
#(
    parameter int CHUNKS_PER_BUNDLE = FETCH_CHUNKS_PER_BUNDLE
) (
    input  logic                                            CLK,
    input  logic                                            RST,
    input  logic                                            restart,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [16*CHUNKS_PER_BUNDLE-1:0]                 in_chunks,
    input  logic [BTB_PRED_INFO_WIDTH*CHUNKS_PER_BUNDLE-1:0] in_pred_info,
    input  logic [$clog2(CHUNKS_PER_BUNDLE)-1:0]            in_start_idx,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic                                            out_uncompressed,
    output logic [31:0]                                     out_instr32,
    output logic [BTB_PRED_INFO_WIDTH-1:0]                  out_pred_info_chunk0,
    output logic [BTB_PRED_INFO_WIDTH-1:0]                  out_pred_info_chunk1,
    output logic                                            out_straddle
);

    localparam int N     = CHUNKS_PER_BUNDLE;
    localparam int PW    = BTB_PRED_INFO_WIDTH;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'(N - 2);

    logic                   bundle_valid_q, bundle_valid_d;
    logic [N-1:0][15:0]     chunks_q, chunks_d;
    logic [N-1:0][PW-1:0]   preds_q, preds_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   straddle_valid_q, straddle_valid_d;
    chunk_t                 straddle_chunk_q, straddle_chunk_d;
    logic [PW-1:0]          straddle_pred_q, straddle_pred_d;

    chunk_t                 lo_chunk, hi_chunk;
    logic [PW-1:0]          lo_pred, hi_pred;
    logic                   use_straddle, lo_uncomp, instr_uncomp, park;
    logic                   fire, ends_bundle, final_consume, accept;
    logic [IDX_W-1:0]       ptr_step;

    instr_chunk_aligner_chunk_select #(
        .N  (N),
        .PW (PW)
    ) u_chunk_select (
        .chunks         (chunks_q),
        .preds          (preds_q),
        .ptr            (ptr_q),
        .use_straddle   (use_straddle),
        .straddle_chunk (straddle_chunk_q),
        .straddle_pred  (straddle_pred_q),
        .lo_chunk       (lo_chunk),
        .hi_chunk       (hi_chunk),
        .lo_pred        (lo_pred),
        .hi_pred        (hi_pred)
    );

    always_comb begin
        use_straddle  = straddle_valid_q && (ptr_q == '0);
        lo_uncomp     = is_uncompressed(lo_chunk);
        // A 32-bit instruction starting in the last slot must wait for its upper half.
        park          = bundle_valid_q && !use_straddle && (ptr_q == LAST_IDX) && lo_uncomp;
        out_valid     = bundle_valid_q && !park;
        instr_uncomp  = use_straddle || lo_uncomp;
        fire          = out_valid && out_ready;
        ptr_step      = ptr_q + ((lo_uncomp && !use_straddle) ? IDX_W'(2) : IDX_W'(1));
        ends_bundle   = !use_straddle && (lo_uncomp ? (ptr_q == PEN_IDX) : (ptr_q == LAST_IDX));
        final_consume = (fire && ends_bundle) || park;
        in_ready      = !bundle_valid_q || final_consume;
        accept        = in_valid && in_ready;

        out_uncompressed     = out_valid && instr_uncomp;
        out_straddle         = out_valid && use_straddle;
        out_instr32          = '0;
        out_pred_info_chunk0 = '0;
        out_pred_info_chunk1 = '0;
        if (out_valid) begin
            out_instr32          = instr_uncomp ? {hi_chunk, lo_chunk} : {16'h0, lo_chunk};
            out_pred_info_chunk0 = lo_pred;
            out_pred_info_chunk1 = instr_uncomp ? hi_pred : '0;
        end
    end

    always_comb begin
        bundle_valid_d   = bundle_valid_q;
        chunks_d         = chunks_q;
        preds_d          = preds_q;
        ptr_d            = ptr_q;
        straddle_valid_d = straddle_valid_q;
        straddle_chunk_d = straddle_chunk_q;
        straddle_pred_d  = straddle_pred_q;

        if (fire) begin
            ptr_d = ptr_step;
            if (use_straddle) straddle_valid_d = 1'b0;
            if (ends_bundle)  bundle_valid_d   = 1'b0;
        end
        if (park) begin
            straddle_valid_d = 1'b1;
            straddle_chunk_d = lo_chunk;
            straddle_pred_d  = lo_pred;
            bundle_valid_d   = 1'b0;
            ptr_d            = '0;
        end
        if (accept) begin
            bundle_valid_d = 1'b1;
            chunks_d       = in_chunks;
            preds_d        = in_pred_info;
            ptr_d          = in_start_idx;
            // Entering mid-bundle means a redirect, so a parked lower half is stale.
            if (in_start_idx != '0) straddle_valid_d = 1'b0;
        end
        if (restart) begin
            bundle_valid_d   = 1'b0;
            chunks_d         = '0;
            preds_d          = '0;
            ptr_d            = '0;
            straddle_valid_d = 1'b0;
            straddle_chunk_d = '0;
            straddle_pred_d  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bundle_valid_q   <= 1'b0;
            chunks_q         <= '0;
            preds_q          <= '0;
            ptr_q            <= '0;
            straddle_valid_q <= 1'b0;
            straddle_chunk_q <= '0;
            straddle_pred_q  <= '0;
        end else begin
            bundle_valid_q   <= bundle_valid_d;
            chunks_q         <= chunks_d;
            preds_q          <= preds_d;
            ptr_q            <= ptr_d;
            straddle_valid_q <= straddle_valid_d;
            straddle_chunk_q <= straddle_chunk_d;
            straddle_pred_q  <= straddle_pred_d;
        end
    end

endmodule

// File: tb/tb_instr_chunk_aligner.sv
// Directed scenarios plus randomized traffic against a bundle-walking reference model.
`timescale 1ns/1ps
module tb_instr_chunk_aligner;
    import core_types_pkg::*;

    localparam int N  = 4;
    localparam int PW = BTB_PRED_INFO_WIDTH;
    localparam int OW = 4 + 32 + 2 * PW;

    typedef logic [OW-1:0] obs_t;
    typedef struct packed {
        logic [31:0]   instr;
        logic          u;
        logic          s;
        logic [PW-1:0] p0;
        logic [PW-1:0] p1;
    } exp_t;

    localparam obs_t RDY_MASK = ~(obs_t'(1) << (OW - 2));

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              restart = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [16*N-1:0]   in_chunks = '0;
    logic [PW*N-1:0]   in_pred_info = '0;
    logic [1:0]        in_start_idx = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_uncompressed;
    logic [31:0]       out_instr32;
    logic [PW-1:0]     out_pred_info_chunk0;
    logic [PW-1:0]     out_pred_info_chunk1;
    logic              out_straddle;

    int vectors     = 0;
    int miscompares = 0;

    exp_t          q[$];
    logic          pend_v = 1'b0;
    chunk_t        pend_c = '0;
    logic [PW-1:0] pend_p = '0;

    always #5 CLK = ~CLK;

    instr_chunk_aligner #(.CHUNKS_PER_BUNDLE(N)) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .restart              (restart),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_chunks            (in_chunks),
        .in_pred_info         (in_pred_info),
        .in_start_idx         (in_start_idx),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_uncompressed     (out_uncompressed),
        .out_instr32          (out_instr32),
        .out_pred_info_chunk0 (out_pred_info_chunk0),
        .out_pred_info_chunk1 (out_pred_info_chunk1),
        .out_straddle         (out_straddle)
    );

    function automatic obs_t mk(input logic v, input logic r, input logic u, input logic s,
                                input logic [31:0] i, input logic [PW-1:0] a, input logic [PW-1:0] b);
        return {v, r, u, s, i, a, b};
    endfunction

    function automatic obs_t cur();
        return {out_valid, in_ready, out_uncompressed, out_straddle, out_instr32,
                out_pred_info_chunk0, out_pred_info_chunk1};
    endfunction

    function automatic chunk_t rand_chunk();
        chunk_t c = chunk_t'($urandom);
        if ($urandom_range(0, 1) == 0) c[1:0] = 2'b11;
        else if (c[1:0] == 2'b11)      c[1:0] = 2'b01;
        return c;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_bundle(input chunk_t c0, input chunk_t c1, input chunk_t c2, input chunk_t c3,
                              input logic [PW-1:0] pb, input logic [1:0] st);
        in_chunks    = {c3, c2, c1, c0};
        in_pred_info = {pb + PW'(3), pb + PW'(2), pb + PW'(1), pb};
        in_start_idx = st;
    endtask

    // Reference: walk a bundle chunk by chunk and list the instructions it will yield.
    task automatic model_accept(input logic [16*N-1:0] ch, input logic [PW*N-1:0] pr, input int s);
        exp_t   e;
        chunk_t c;
        int     i;
        if (s != 0) pend_v = 1'b0;
        i = s;
        while (i < N) begin
            c = ch[16*i +: 16];
            e = '0;
            if (pend_v && i == 0) begin
                e.instr = {c, pend_c}; e.u = 1'b1; e.s = 1'b1;
                e.p0 = pend_p; e.p1 = pr[0 +: PW];
                q.push_back(e);
                pend_v = 1'b0;
                i = 1;
            end else if (c[1:0] != 2'b11) begin
                e.instr = {16'h0, c}; e.p0 = pr[PW*i +: PW];
                q.push_back(e);
                i = i + 1;
            end else if (i == N - 1) begin
                pend_v = 1'b1; pend_c = c; pend_p = pr[PW*i +: PW];
                i = N;
            end else begin
                e.instr = {ch[16*(i+1) +: 16], c}; e.u = 1'b1;
                e.p0 = pr[PW*i +: PW]; e.p1 = pr[PW*(i+1) +: PW];
                q.push_back(e);
                i = i + 2;
            end
        end
    endtask

    task automatic test_reset();
        obs_t e;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        e = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        vectors++;
        if (cur() !== e) begin miscompares++; $display("FAIL reset got %h want %h", cur(), e); end
        tick();
    endtask

    task automatic test_compressed();
        obs_t        e;
        logic [31:0] want [4];
        want[0] = 32'h1; want[1] = 32'h5; want[2] = 32'h9; want[3] = 32'hD;
        out_ready = 1'b1;
        set_bundle(16'h0001, 16'h0005, 16'h0009, 16'h000D, 8'h10, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (k < 4) e = mk(1'b1, k == 3, 1'b0, 1'b0, want[k], 8'(16 + k), 8'h0);
            else       e = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
            vectors++;
            if (cur() !== e) begin miscompares++; $display("FAIL compressed[%0d] got %h want %h", k, cur(), e); end
            tick();
        end
    endtask

    task automatic test_uncompressed();
        obs_t tbl [4];
        tbl[0] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0513, 8'h20, 8'h21);
        tbl[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 8'h22, 8'h00);
        tbl[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0005, 8'h23, 8'h00);
        tbl[3] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        out_ready = 1'b1;
        set_bundle(16'h0513, 16'h0000, 16'h0001, 16'h0005, 8'h20, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            vectors++;
            if (cur() !== tbl[k]) begin miscompares++; $display("FAIL uncompressed[%0d] got %h want %h", k, cur(), tbl[k]); end
            tick();
        end
    endtask

    task automatic test_straddle();
        obs_t tbl [9];
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 8'hA0, 8'h0);
        tbl[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 8'hA1, 8'h0);
        tbl[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h9, 8'hA2, 8'h0);
        tbl[3] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        tbl[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        tbl[5] = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h0010_0093, 8'hA3, 8'hB0);
        tbl[6] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 8'hB1, 8'h0);
        tbl[7] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 8'hB2, 8'h0);
        tbl[8] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h9, 8'hB3, 8'h0);
        out_ready = 1'b1;
        set_bundle(16'h0001, 16'h0005, 16'h0009, 16'h0093, 8'hA0, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) begin
                set_bundle(16'h0010, 16'h0001, 16'h0005, 16'h0009, 8'hB0, 2'd0);
                in_valid = 1'b1;
            end
            @(negedge CLK);
            vectors++;
            if (cur() !== tbl[k]) begin miscompares++; $display("FAIL straddle[%0d] got %h want %h", k, cur(), tbl[k]); end
            tick();
            in_valid = 1'b0;
        end
        tick();
    endtask

    task automatic test_start_idx();
        obs_t tbl [8];
        out_ready = 1'b1;
        set_bundle(16'h0513, 16'h0000, 16'h0015, 16'h0001, 8'h30, 2'd2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h15, 8'h32, 8'h0);
        tbl[1] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h01, 8'h33, 8'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            vectors++;
            if (cur() !== tbl[k]) begin miscompares++; $display("FAIL start_idx[%0d] got %h want %h", k, cur(), tbl[k]); end
            tick();
        end
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 8'h40, 8'h0);
        tbl[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 8'h41, 8'h0);
        tbl[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h9, 8'h42, 8'h0);
        tbl[3] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        tbl[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        tbl[5] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h9, 8'h51, 8'h0);
        tbl[6] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 8'h52, 8'h0);
        tbl[7] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 8'h53, 8'h0);
        set_bundle(16'h0001, 16'h0005, 16'h0009, 16'h0093, 8'h40, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                set_bundle(16'h0010, 16'h0009, 16'h0001, 16'h0005, 8'h50, 2'd1);
                in_valid = 1'b1;
            end
            @(negedge CLK);
            vectors++;
            if (cur() !== tbl[k]) begin miscompares++; $display("FAIL straddle_drop[%0d] got %h want %h", k, cur(), tbl[k]); end
            tick();
            in_valid = 1'b0;
        end
        tick();
    endtask

    task automatic test_stall();
        obs_t e;
        set_bundle(16'h0001, 16'h0005, 16'h0009, 16'h000D, 8'h60, 2'd0);
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            out_ready = (k >= 3);
            @(negedge CLK);
            if (k < 3)       e = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 8'h60, 8'h0);
            else if (k < 7)  e = mk(1'b1, k == 6, 1'b0, 1'b0, 32'(4 * (k - 3) + 1), 8'(8'h60 + k - 3), 8'h0);
            else             e = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
            vectors++;
            if (cur() !== e) begin miscompares++; $display("FAIL stall[%0d] got %h want %h", k, cur(), e); end
            tick();
        end
    endtask

    task automatic test_restart();
        obs_t e;
        out_ready = 1'b1;
        set_bundle(16'h0001, 16'h0005, 16'h0009, 16'h0093, 8'h70, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        set_bundle(16'h0010, 16'h0001, 16'h0005, 16'h0009, 8'h80, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        restart = 1'b1;
        @(negedge CLK);
        e = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h0010_0093, 8'h73, 8'h80);
        vectors++;
        if (cur() !== e) begin miscompares++; $display("FAIL restart_pre got %h want %h", cur(), e); end
        tick();
        restart = 1'b0;
        @(negedge CLK);
        e = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        vectors++;
        if (cur() !== e) begin miscompares++; $display("FAIL restart_post got %h want %h", cur(), e); end
        out_ready = 1'b1;
        set_bundle(16'h0001, 16'h0005, 16'h0009, 16'h000D, 8'h90, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge CLK);
        e = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 8'h90, 8'h0);
        vectors++;
        if (cur() !== e) begin miscompares++; $display("FAIL restart_next got %h want %h", cur(), e); end
        repeat (4) tick();
    endtask

    task automatic test_async_reset();
        obs_t e;
        out_ready = 1'b1;
        set_bundle(16'h0001, 16'h0005, 16'h0009, 16'h000D, 8'hC0, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        RST = 1'b1;
        #1;
        e = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        vectors++;
        if (cur() !== e) begin miscompares++; $display("FAIL async_rst got %h want %h", cur(), e); end
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if (cur() !== e) begin miscompares++; $display("FAIL async_rst_after got %h want %h", cur(), e); end
        tick();
    endtask

    task automatic test_random();
        exp_t e;
        obs_t x;
        RST = 1'b1;
        #2;
        RST = 1'b0;
        tick();
        q.delete();
        pend_v = 1'b0;
        for (int cyc = 0; cyc < 1520; cyc++) begin
            in_valid  = (cyc < 1500) && ($urandom_range(0, 3) != 0);
            out_ready = (cyc >= 1500) || ($urandom_range(0, 3) != 0);
            for (int j = 0; j < N; j++) begin
                in_chunks[16*j +: 16]   = rand_chunk();
                in_pred_info[PW*j +: PW] = PW'($urandom);
            end
            in_start_idx = 2'd0;
            if ($urandom_range(0, 3) == 0) in_start_idx = 2'($urandom_range(1, 3));
            @(negedge CLK);
            if (out_valid) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra_output got %h want none", cur());
                end else begin
                    e = q[0];
                    x = mk(1'b1, 1'b0, e.u, e.s, e.instr, e.p0, e.p1);
                    if ((cur() & RDY_MASK) !== (x & RDY_MASK)) begin
                        miscompares++;
                        $display("FAIL rand_output[%0d] got %h want %h", cyc, cur() & RDY_MASK, x & RDY_MASK);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) model_accept(in_chunks, in_pred_info, int'(in_start_idx));
            tick();
        end
        in_valid = 1'b0;
        @(negedge CLK);
        vectors++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_drain got %0d pending valid=%b want 0 pending valid=0", q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_compressed();
        test_uncompressed();
        test_straddle();
        test_start_idx();
        test_stall();
        test_restart();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_chunk_aligner.md
Name: instr_chunk_aligner

Overview:
- Sits between the fetch/predecode stage and the instruction decoder.
- Takes fetch bundles of 16-bit chunks, each with per-chunk BTB prediction info, and re-aligns them into one instruction per cycle on the decoder's input interface (uncompressed, instr32, pred_info_chunk0, pred_info_chunk1).
- Buffers a 32-bit instruction whose lower chunk ends one bundle and whose upper chunk starts the next.

Parameters:
- CHUNKS_PER_BUNDLE, 4: 16-bit chunks per fetch bundle; power of 2, at least 2.
- BTB_PRED_INFO_WIDTH, from core_types_pkg: width of the per-chunk prediction info.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- restart  in  1  fetch redirect; discards all buffered state.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  aligner accepts the bundle this cycle.
- in_chunks  in  16*CHUNKS_PER_BUNDLE  bundle chunks; chunk i is bits [16i+15:16i].
- in_pred_info  in  BTB_PRED_INFO_WIDTH*CHUNKS_PER_BUNDLE  pred info for each chunk.
- in_start_idx  in  log2(CHUNKS_PER_BUNDLE)  first valid chunk (redirect target within the bundle).
- out_valid  out  1  aligned instruction valid.
- out_ready  in  1  decoder consumes the instruction.
- out_uncompressed  out  1  instruction is 32-bit.
- out_instr32  out  32  instruction; upper 16 bits are zero when compressed.
- out_pred_info_chunk0  out  BTB_PRED_INFO_WIDTH  pred info of the lower chunk.
- out_pred_info_chunk1  out  BTB_PRED_INFO_WIDTH  pred info of the upper chunk; '0 when compressed.
- out_straddle  out  1  lower chunk came from the previous bundle.

Behaviour:
- Reset: all outputs 0. in_ready is 1 after reset. Bundle register, pointer and straddle buffer are empty or 0.
- restart: same effect as reset at the next edge. Overrides in_valid and out_ready that cycle. No fire is recorded.
- State: bundle_valid, ptr, straddle_valid with straddle_chunk and straddle_pred.
- A chunk is uncompressed when chunk[1:0] == 2'b11.
- Accept: in_valid & in_ready at edge N loads the bundle and sets ptr = in_start_idx. First out_valid appears in cycle N+1; outputs are driven from registered state.
- in_ready = ~bundle_valid | final_consume, where final_consume is true when this cycle removes the last remaining chunk(s) of the bundle. This allows back-to-back bundles with no bubble.
- Straddle output (straddle_valid & bundle_valid & ptr == 0):
  - out_valid = 1, uncompressed = 1, instr32 = {bundle[0], straddle_chunk}.
  - pred0 = straddle_pred, pred1 = pred[0], out_straddle = 1.
  - On fire: ptr becomes 1 and straddle_valid clears.
- Straddle dropped: if straddle_valid and the accepted bundle has in_start_idx != 0, the straddle is discarded (treated as a redirect) and no output is made from it.
- Normal output with ptr < CHUNKS_PER_BUNDLE-1:
  - If the chunk is compressed: instr32 = {16'h0, chunk[ptr]}, pred0 = pred[ptr], pred1 = '0, and ptr advances by 1 on fire.
  - If the chunk is uncompressed: instr32 = {chunk[ptr+1], chunk[ptr]}, pred0 = pred[ptr], pred1 = pred[ptr+1], and ptr advances by 2 on fire.
- Last chunk (ptr == CHUNKS_PER_BUNDLE-1):
  - Compressed: output as above. Its fire is final_consume.
  - Uncompressed: out_valid = 0. Chunk and pred move to the straddle buffer unconditionally that cycle, bundle_valid clears, and in_ready = 1 (counts as final_consume).
- ptr wrap: reaching CHUNKS_PER_BUNDLE clears bundle_valid and ptr wraps to 0. A 32-bit instruction at ptr = CHUNKS_PER_BUNDLE-2 fully consumes the bundle.
- Stall: out_valid held with out_ready = 0 keeps all outputs stable; no state changes.
- At most one instruction per cycle; no output while the straddle buffer is waiting for the next bundle.

Decomposition:
- core_types_pkg: BTB_PRED_INFO_WIDTH, a CHUNKS_PER_BUNDLE constant, and a chunk-index typedef.
- One natural sub-module, chunk_select: a combinational mux producing the lower and upper chunk plus pred info from the bundle, ptr and the straddle buffer.
- Everything else (state, handshake, pointer) lives in the top module.

Test Plan:
- Reset, then a bundle of four compressed chunks 0x0001, 0x0005, 0x0009, 0x000D, start 0: four consecutive outputs with instr32 = 0x00000001, 0x00000005, 0x00000009, 0x0000000D, uncompressed = 0, pred1 = 0. in_ready = 1 on the fourth output cycle.
- Bundle of chunks 0x0513, 0x0000 (addi) then 0x0001 at index 2, start 0: first output instr32 = 0x00000513, uncompressed = 1, pred0 = pred[0], pred1 = pred[1]; next output 0x00000001.
- Straddle: bundle A ends with a lower chunk 0x0093 at index 3, then bundle B with chunk0 = 0x0010. Expect no output for A[3] and in_ready = 1 that cycle; then instr32 = 0x00100093 with out_straddle = 1, pred0 = A.pred[3], pred1 = B.pred[0].
- in_start_idx = 2 with a compressed chunk at index 2: first output comes from chunk 2. Pending straddle followed by a bundle with in_start_idx = 1: the straddle is dropped and no straddle output occurs.
- Hold out_ready = 0 for 3 cycles: outputs stay stable and in_ready = 0; release gives exactly one fire per cycle.
- Assert restart mid-bundle with a straddle pending, and separately assert RST asynchronously mid-bundle: next cycle out_valid = 0, in_ready = 1, out_straddle = 0, and all outputs are 0.
